// File: rtl/packet_pkg.sv
// Shared field layout, record format and FSM encoding for the packet sink slice.
// Packet layout (38b): DST | GEN | NODE | F_LR | F_DUAL | F_EXT | F_LAST | DATA.
package packet_pkg;

  localparam int DST_W  = 3;
  localparam int GEN_W  = 8;
  localparam int NODE_W = 7;
  localparam int DATA_W = 16;
  localparam int PKT_W  = 38;

  localparam int DATA_LSB   = 0;
  localparam int F_LAST_BIT = 16;
  localparam int F_EXT_BIT  = 17;
  localparam int F_DUAL_BIT = 18;
  localparam int F_LR_BIT   = 19;
  localparam int NODE_LSB   = 20;
  localparam int GEN_LSB    = 27;
  localparam int DST_LSB    = 35;

  localparam int REC_W = GEN_W + NODE_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } sink_state_e;

  typedef struct packed {
    logic [DST_W-1:0]  dst;
    logic [GEN_W-1:0]  gen;
    logic [NODE_W-1:0] node;
    logic              f_lr;
    logic              f_dual;
    logic              f_ext;
    logic              f_last;
    logic [DATA_W-1:0] data;
  } pkt_t;

  typedef struct packed {
    logic [GEN_W-1:0]  gen;
    logic [NODE_W-1:0] node;
    logic [DATA_W-1:0] data;
  } rec_t;

  function automatic rec_t pkt_to_rec(input pkt_t p);
    rec_t r;
    r.gen  = p.gen;
    r.node = p.node;
    r.data = p.data;
    return r;
  endfunction

endpackage

// File: rtl/packet_sink_if.sv
// Packet stream handshake between the fetch stage (master) and the sink (slave).
interface packet_sink_if;
  import packet_pkg::*;

  pkt_t pkt_in;
  logic pkt_valid;
  logic pkt_ready;

  modport master (output pkt_in, output pkt_valid, input pkt_ready);
  modport slave  (input pkt_in, input pkt_valid, output pkt_ready);

endinterface

// File: rtl/packet_sink_fifo.sv
// Synchronous FIFO holding accepted packet records for the host reader.
// Latency: a push is visible at the head after its edge; rd_data is combinational from storage.
// Backpressure: push ignored when full, pop ignored when empty.
module packet_sink_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = packet_pkg::REC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Masked while empty so the read port shows zero instead of stale storage.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/packet_sink.sv
// Packet sink: filters packets by destination, buffers records, closes frames on LAST. Optional PACKET_SINK_STATS_EN adds counters.
// Latency: accepted record readable one edge after transfer; FRAME_DONE rises after the LAST transfer edge.
// Backpressure: pkt_ready drops while the FIFO is full or a closed frame awaits done_ack.
module packet_sink
  import packet_pkg::*;
#(
  parameter logic [DST_W-1:0] SINK_ID = 3'b111,
  parameter int               DEPTH   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  packet_sink_if.slave      pkt_if,
  input  logic              rd_en,
  output logic [REC_W-1:0]  rd_data,
  output logic              empty,
  output logic              full,
  output logic              frame_done,
  input  logic              done_ack,
  output logic              overflow
`ifdef PACKET_SINK_STATS_EN
  ,
  output logic [15:0]       acc_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  sink_state_e state;
  logic        dst_match;
  logic        xfer;
  logic        push;
  logic        unused_flags;
  rec_t        rec;

  assign dst_match = (pkt_if.pkt_in.dst == SINK_ID);
  assign xfer      = pkt_if.pkt_valid & pkt_if.pkt_ready;
  assign push      = xfer & dst_match;
  assign rec       = pkt_to_rec(pkt_if.pkt_in);

  assign unused_flags = ^{pkt_if.pkt_in.f_lr, pkt_if.pkt_in.f_dual, pkt_if.pkt_in.f_ext};

  assign pkt_if.pkt_ready = (state != DONE) & ~full;

  packet_sink_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (rec),
    .pop     (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  // A LAST packet taken straight out of IDLE closes the frame immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (push && pkt_if.pkt_in.f_last) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else if (xfer) begin
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (push && pkt_if.pkt_in.f_last) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          if (done_ack) begin
            state      <= IDLE;
            frame_done <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

  // Flags an upstream stall on a packet this sink would have kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (pkt_if.pkt_valid && dst_match && full && (state != DONE)) begin
      overflow <= 1'b1;
    end
  end

`ifdef PACKET_SINK_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt  <= '0;
      drop_cnt <= '0;
    end else if (xfer) begin
      if (dst_match) begin
        if (acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
      end else begin
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_packet_sink.sv
// Scoreboard bench for packet_sink: directed test-plan sequences followed by a randomized phase.
module tb_packet_sink;
  import packet_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  packet_sink_if pif ();

  logic             rd_en = 1'b0;
  logic             done_ack = 1'b0;
  logic [REC_W-1:0] rd_data;
  logic             empty, full, frame_done, overflow;
`ifdef PACKET_SINK_STATS_EN
  logic [15:0]      acc_cnt, drop_cnt;
`endif

  packet_sink #(.SINK_ID(3'b111), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pkt_if     (pif),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .frame_done (frame_done),
    .done_ack   (done_ack),
    .overflow   (overflow)
`ifdef PACKET_SINK_STATS_EN
    ,
    .acc_cnt    (acc_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  // Reference model: expected record queue plus frame/overflow/count state.
  logic [REC_W-1:0] exp_q[$];
  bit               m_closed = 0;
  bit               m_ovf = 0;
  int               m_acc = 0;
  int               m_drop = 0;
  int               checks = 0;
  int               failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = exp_q.size();
    chk("pkt_ready", 32'(pif.pkt_ready), 32'(!m_closed && n < DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("frame_done", 32'(frame_done), 32'(m_closed));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (n == 0) chk("rd_data_when_empty", 32'(rd_data), 32'd0);
`ifdef PACKET_SINK_STATS_EN
    chk("acc_cnt", 32'(acc_cnt), 32'(m_acc));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  // One clock: check outputs, then drive inputs for the next edge and advance the model.
  task automatic cycle(input bit v, input pkt_t p, input bit rd, input bit ack, output bit xfer);
    bit match;
    bit was_closed;
    @(negedge clk);
    check_outputs();
    was_closed = m_closed;
    match = (p.dst == 3'b111);
    xfer = v && !m_closed && (exp_q.size() < DEPTH);
    if (v && match && !m_closed && exp_q.size() == DEPTH) m_ovf = 1;
    if (xfer) begin
      if (match) begin
        exp_q.push_back({p.gen, p.node, p.data});
        if (m_acc < 65535) m_acc++;
        if (p.f_last) m_closed = 1;
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
    if (ack && was_closed) m_closed = 0;
    pif.pkt_valid = v;
    pif.pkt_in    = p;
    rd_en         = rd;
    done_ack      = ack;
  endtask

  function automatic pkt_t mk(input logic [2:0] dst, input logic [15:0] data, input bit last);
    pkt_t p;
    p.dst    = dst;
    p.gen    = 8'($urandom);
    p.node   = 7'($urandom);
    p.f_lr   = 1'($urandom);
    p.f_dual = 1'($urandom);
    p.f_ext  = 1'($urandom);
    p.f_last = last;
    p.data   = data;
    return p;
  endfunction

  task automatic send(input pkt_t p, input bit rd);
    bit x;
    int k;
    k = 0;
    x = 0;
    while (!x && k < 100) begin
      cycle(1'b1, p, rd, 1'b0, x);
      k++;
    end
    if (!x) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no transfer required transfer within 100 cycles");
    end
  endtask

  task automatic idle(input int n, input bit rd);
    bit x;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, rd, 1'b0, x);
  endtask

  task automatic drain();
    bit x;
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) cycle(1'b0, '0, 1'b1, 1'b0, x);
    idle(1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    pif.pkt_valid = 1'b0;
    pif.pkt_in    = '0;
    rd_en         = 1'b0;
    done_ack      = 1'b0;
    exp_q.delete();
    m_closed = 0;
    m_ovf    = 0;
    m_acc    = 0;
    m_drop   = 0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  // Monitor: every pop the DUT performs is compared against the scoreboard head.
  initial begin
    logic [REC_W-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && rd_en && !empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected: got rd_data 0x%0h required no entry", rd_data);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", 32'(rd_data), 32'(e));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required $finish before 400000");
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_t p, q;
    bit   x;
    bit   v, rd, ack, last;
    logic [2:0] dst;

    pif.pkt_valid = 1'b0;
    pif.pkt_in    = '0;
    do_reset();

    // In-order delivery of two matching packets.
    send(mk(3'b111, 16'd4, 1'b0), 1'b0);
    send(mk(3'b111, 16'd5, 1'b0), 1'b0);
    idle(2, 1'b0);
    drain();

    // Mismatching destination is dropped.
    send(mk(3'b011, 16'd9, 1'b0), 1'b0);
    send(mk(3'b111, 16'd2, 1'b0), 1'b0);
    idle(1, 1'b0);
    drain();

    // Frame close, held-off VALID, acknowledge.
    p = mk(3'b111, 16'd6, 1'b1);
    p.node = 7'd7;
    send(p, 1'b0);
    q = mk(3'b111, 16'd8, 1'b0);
    repeat (3) cycle(1'b1, q, 1'b0, 1'b0, x);
    cycle(1'b1, q, 1'b0, 1'b1, x);
    send(q, 1'b0);
    drain();

    // Fill to DEPTH, stall a 17th packet into overflow, then free one slot.
    for (int i = 0; i < DEPTH; i++) send(mk(3'b111, 16'(i), 1'b0), 1'b0);
    p = mk(3'b111, 16'd16, 1'b0);
    repeat (3) cycle(1'b1, p, 1'b0, 1'b0, x);
    cycle(1'b1, p, 1'b1, 1'b0, x);
    send(p, 1'b0);
    drain();

    // Reset mid-frame flushes everything; reads on empty do nothing.
    for (int i = 0; i < 3; i++) send(mk(3'b111, 16'(100 + i), 1'b0), 1'b0);
    do_reset();
    idle(3, 1'b1);

    // Forty back-to-back push/pop pairs wrap the pointers.
    for (int i = 0; i < 40; i++) send(mk(3'b111, 16'(i), 1'b0), 1'b1);
    idle(1, 1'b1);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      dst  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      last = ($urandom_range(0, 19) == 0);
      rd   = ($urandom_range(0, 2) == 0);
      ack  = ($urandom_range(0, 5) == 0);
      cycle(v, mk(dst, 16'($urandom), last), rd, ack, x);
    end
    drain();
    idle(2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/packet_sink.md
# packet_sink

Receiving end of the 38-bit token-packet stream produced by the packet fetch stage. Accepts packets over a valid/ready handshake, decodes the fixed field layout, keeps only packets addressed to this sink, and buffers their node/generation/data in a FIFO for the host-side reader. A frame is closed by a packet carrying the LAST flag. Closing a frame raises a sticky completion flag that the reader acknowledges.

## Interface
- SINK_ID, 3'b111, destination code accepted by this sink.
- DEPTH, 16, FIFO entries (power of two, ≥2).
- CLK  in  1  rising-edge clock, sole clock domain.
- RST_N  in  1  asynchronous, active-low reset.
- PKT_IN  in  38  packet: [37:35] DST, [34:27] GEN, [26:20] NODE, [19] F_LR, [18] F_DUAL, [17] F_EXT, [16] F_LAST, [15:0] DATA.
- PKT_VALID  in  1  PKT_IN valid.
- PKT_READY  out  1  sink can take a packet this cycle.
- RD_EN  in  1  pop one FIFO entry.
- RD_DATA  out  31  {GEN[7:0], NODE[6:0], DATA[15:0]} of head entry.
- EMPTY  out  1  FIFO empty.
- FULL  out  1  FIFO full.
- FRAME_DONE  out  1  sticky: a LAST packet was accepted.
- DONE_ACK  in  1  clears FRAME_DONE and reopens collection.
- OVERFLOW  out  1  sticky: a matching packet arrived while FULL.

## Operation
- Transfer occurs when PKT_VALID & PKT_READY are high at a rising CLK edge.
- The DST of each transferred packet is compared to SINK_ID.
  - Match: push {GEN, NODE, DATA} into the FIFO.
  - Mismatch: discard silently; no FIFO change.
- Flags F_LR, F_DUAL and F_EXT are ignored. F_LAST on a matching packet ends the frame.
- FSM states:
  - IDLE: after reset; first transfer moves to COLLECT (the packet itself is processed).
  - COLLECT: accept and push. A matching packet with F_LAST → DONE.
  - DONE: PKT_READY=0; FRAME_DONE=1. DONE_ACK → IDLE.
- PKT_READY = (state≠DONE) & ~FULL.
- Matching packet while FULL:
  - Cannot transfer, because READY is low.
  - OVERFLOW sets when PKT_VALID & DST match & FULL & state≠DONE, i.e. upstream is stalled.
  - OVERFLOW is cleared only by reset.
- Read: RD_EN with ~EMPTY pops the head. RD_EN when EMPTY is ignored.
- Simultaneous push and pop when FULL is impossible, because READY is low. When EMPTY and pushing, RD_EN is ignored that cycle.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. FULL/EMPTY are derived from the MSB/equality of the pointers.
- Reset mid-frame flushes the FIFO, returns to IDLE and clears FRAME_DONE and OVERFLOW.

## Timing
- Reset values: PKT_READY=1, EMPTY=1, FULL=0, FRAME_DONE=0, OVERFLOW=0, RD_DATA=0.
- Push latency: an entry accepted at edge N is visible on RD_DATA, with EMPTY=0, after edge N.
- RD_DATA is combinational from the head of the registered storage. A pop at edge N presents the next entry after N.
- FRAME_DONE rises after the edge accepting the LAST packet. READY falls at the same time.
- DONE_ACK sampled at edge M: FRAME_DONE=0 and READY restored after M. DONE_ACK outside DONE is ignored.
- FULL/EMPTY update on the same edge as the push/pop that changes them.

## Configuration
- PACKET_SINK_STATS_EN:
  - Defined: adds outputs ACC_CNT[15:0] and DROP_CNT[15:0].
    - ACC_CNT counts matching packets transferred; DROP_CNT counts mismatching packets transferred.
    - Both saturate at 16'hFFFF, reset to 0, and are not cleared by DONE_ACK.
  - Undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package packet_pkg:
  - Field width/offset constants (DST_W=3, GEN_W=8, NODE_W=7, DATA_W=16, PKT_W=38).
  - Flag bit indices.
  - The FSM state enum: IDLE=2'd0, COLLECT=2'd1, DONE=2'd2.
  - The record width (31).
- One sub-module, packet_sink_fifo: synchronous FIFO with DEPTH parameter, push/pop/full/empty and asynchronous active-low reset.
- The top module holds the decode, FSM, sticky flags and optional counters.

## Test plan
- Reset, then send packets DST=111/DATA=4, then DST=111/DATA=5 → RD_DATA shows DATA 4, then 5; EMPTY=0 until two pops.
- Send DST=011 DATA=9 then DST=111 DATA=2 → only DATA 2 stored; with STATS_EN, ACC_CNT=1 and DROP_CNT=1.
- Send DST=111, NODE=7, F_LAST=1, DATA=6 → FRAME_DONE=1 and READY=0 next cycle; next VALID is held off; DONE_ACK → READY=1 and FRAME_DONE=0.
- Push DEPTH matching packets without reads → FULL=1, READY=0; a 17th VALID sets OVERFLOW; one pop → READY=1 and the packet is accepted.
- Fill 3 entries, assert RST_N=0 mid-frame → EMPTY=1, state IDLE, flags 0; RD_EN on empty has no effect.
- Run 40 push/pop pairs with DEPTH=16 → pointers wrap and data order is preserved (DATA 0..39).
